// File: rtl/weight_stream_loader_pkg.sv
// Shared constants and FSM encoding for the weight stream loader.
// Default geometry matches the production weight RAM (8 banks x 4K x 64b).
package weight_stream_loader_pkg;

  localparam int DEF_DATA_W    = 64;
  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_NUM_BANKS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/weight_stream_loader.sv
// Streams AXI-Stream beats into banked weight RAM, one word per accepted beat,
// optionally spilling into following banks; reports short/over-length packets.
module weight_stream_loader
  import weight_stream_loader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  localparam int BANK_W   = $clog2(NUM_BANKS),
  localparam int WL_W     = ADDR_W + BANK_W + 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [BANK_W-1:0] cfg_bank,
  input  logic              cfg_auto_inc,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_reg_adr,
  output logic [BANK_W-1:0] ram_mem_adr,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output logic              err_over,
  output logic [WL_W-1:0]   words_loaded
);

  // Handshake: a beat transfers on a rising CLK edge where s_axis_tvalid and
  // s_axis_tready are both high; tready depends only on the FSM state.

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BANK_W-1:0] bank_q;
  logic              auto_q;
  logic              beat;
  logic              arm;
  logic              at_end;
  logic              can_spill;

  assign s_axis_tready = (state != ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign arm           = cfg_start & (cfg_len != '0);
  // len_q is never zero while loading, so len_q-1 cannot underflow.
  assign at_end        = (addr_q == len_q - 1'b1);
  assign can_spill     = auto_q & (bank_q != BANK_W'(NUM_BANKS - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (arm) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (beat) begin
          if (s_axis_tlast)             state_nxt = ST_IDLE;
          else if (at_end && !can_spill) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat && s_axis_tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      len_q        <= '0;
      addr_q       <= '0;
      bank_q       <= '0;
      auto_q       <= 1'b0;
      ram_din      <= '0;
      ram_reg_adr  <= '0;
      ram_mem_adr  <= '0;
      ram_we       <= 1'b0;
      done         <= 1'b0;
      err_short    <= 1'b0;
      err_over     <= 1'b0;
      words_loaded <= '0;
    end else begin
      ram_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            len_q        <= cfg_len;
            bank_q       <= cfg_bank;
            auto_q       <= cfg_auto_inc;
            addr_q       <= '0;
            err_short    <= 1'b0;
            err_over     <= 1'b0;
            words_loaded <= '0;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            ram_we      <= 1'b1;
            ram_din     <= s_axis_tdata;
            ram_reg_adr <= addr_q;
            ram_mem_adr <= bank_q;
            if (words_loaded != '1) words_loaded <= words_loaded + 1'b1;
            if (at_end && can_spill) begin
              bank_q <= bank_q + 1'b1;
              addr_q <= '0;
            end else if (!at_end) begin
              addr_q <= addr_q + 1'b1;
            end
            // tlast is short unless this beat filled the final slot.
            if (s_axis_tlast) begin
              done <= 1'b1;
              if (!at_end || can_spill) err_short <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (beat) begin
            err_over <= 1'b1;
            if (s_axis_tlast) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Randomised and directed bench for weight_stream_loader, checked every cycle
// against a slot-index model of the packet plus hand-computed write lists.
module tb_weight_stream_loader;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NB   = 8;
  localparam int BW   = 3;
  localparam int WLW  = AW + BW + 1;
  localparam int SB_W = BW + AW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          tready;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_len = '0;
  logic [BW-1:0] cfg_bank = '0;
  logic          cfg_auto_inc = 1'b0;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_reg_adr;
  logic [BW-1:0] ram_mem_adr;
  logic          ram_we;
  logic          busy;
  logic          done;
  logic          err_short;
  logic          err_over;
  logic [WLW-1:0] words_loaded;

  weight_stream_loader #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
    .CLK(clk), .RST_N(rst_n),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_bank(cfg_bank),
    .cfg_auto_inc(cfg_auto_inc),
    .ram_din(ram_din), .ram_reg_adr(ram_reg_adr), .ram_mem_adr(ram_mem_adr),
    .ram_we(ram_we), .busy(busy), .done(done), .err_short(err_short),
    .err_over(err_over), .words_loaded(words_loaded)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // counters and scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit sb_on    = 1'b0;
  logic [SB_W-1:0] exp_q[$];

  // packet model: the packet owns slots 0..cap-1, slot k -> bank first+k/len, addr k%len
  bit            m_busy = 1'b0;
  int            m_len = 0, m_first = 0, m_last = 0, m_idx = 0;
  bit            exp_we = 1'b0, exp_done = 1'b0, exp_es = 1'b0, exp_eo = 1'b0;
  logic [DW-1:0] exp_din = '0;
  int            exp_radr = 0, exp_madr = 0, exp_wl = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int cap;
    exp_we   = 1'b0;
    exp_done = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; exp_din = '0; exp_radr = 0; exp_madr = 0;
      exp_es = 1'b0; exp_eo = 1'b0; exp_wl = 0;
      return;
    end
    if (!m_busy) begin
      if (cfg_start && cfg_len != 0) begin
        m_busy  = 1'b1;
        m_len   = int'(cfg_len);
        m_first = int'(cfg_bank);
        m_last  = cfg_auto_inc ? NB - 1 : int'(cfg_bank);
        m_idx   = 0;
        exp_es  = 1'b0; exp_eo = 1'b0; exp_wl = 0;
      end
    end else if (tvalid) begin
      cap = m_len * (m_last - m_first + 1);
      if (m_idx < cap) begin
        exp_we   = 1'b1;
        exp_din  = tdata;
        exp_madr = m_first + m_idx / m_len;
        exp_radr = m_idx % m_len;
        if (exp_wl < (1 << WLW) - 1) exp_wl++;
      end else begin
        exp_eo = 1'b1;
      end
      m_idx++;
      if (tlast) begin
        exp_done = 1'b1;
        m_busy   = 1'b0;
        if (m_idx < cap) exp_es = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [SB_W-1:0] e;
    chk("tready", tready, m_busy);
    chk("busy", busy, m_busy);
    chk("ram_we", ram_we, exp_we);
    chk("ram_din", ram_din, exp_din);
    chk("ram_reg_adr", ram_reg_adr, exp_radr);
    chk("ram_mem_adr", ram_mem_adr, exp_madr);
    chk("done", done, exp_done);
    chk("err_short", err_short, exp_es);
    chk("err_over", err_over, exp_eo);
    chk("words_loaded", words_loaded, exp_wl);
    if (ram_we === 1'b1 && sb_on) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra: unexpected write bank %0d adr %0d at %0t",
                 ram_mem_adr, ram_reg_adr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_write", {ram_mem_adr, ram_reg_adr, ram_din}, e);
      end
    end
    if (done === 1'b1) done_cnt++;
  endtask

  // one clock: model sees the inputs at the edge, outputs checked 1 unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic arm(input int len, input int bank, input bit auto_inc);
    cfg_start    = 1'b1;
    cfg_len      = AW'(len);
    cfg_bank     = BW'(bank);
    cfg_auto_inc = auto_inc;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic push_exp(input int bank, input int adr, input logic [DW-1:0] d);
    exp_q.push_back({BW'(bank), AW'(adr), d});
  endtask

  task automatic end_directed(input string tag, input int wl, input bit es,
                              input bit eo, input int dones);
    idle(2);
    chk({tag, "_words_loaded"}, words_loaded, wl);
    chk({tag, "_err_short"}, err_short, es);
    chk({tag, "_err_over"}, err_over, eo);
    chk({tag, "_done_cnt"}, done_cnt, dones);
    chk({tag, "_sb_left"}, exp_q.size(), 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  logic [DW-1:0] d[8];
  int            nb, stall, d0;

  initial begin
    for (int i = 0; i < 8; i++) d[i] = $urandom();

    // reset state
    idle(2);
    chk("rst_tready", tready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_words_loaded", words_loaded, 0);
    rst_n = 1'b1;
    idle(1);
    sb_on = 1'b1;

    // len 4, bank 2, no spill, tlast on 4th beat
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) push_exp(2, i, d[i]);
    arm(4, 2, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(d[i], i == 3);
    end_directed("single_bank", 4, 0, 0, d0 + 1);

    // len 3 from bank 6 with spill: banks 6,7 filled, two beats drained
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) push_exp(6 + i / 3, i % 3, d[i]);
    arm(3, 6, 1'b1);
    for (int i = 0; i < 8; i++) send_beat(d[i], i == 7);
    end_directed("spill_drain", 6, 0, 1, d0 + 1);

    // len 5, tlast on 2nd beat
    d0 = done_cnt;
    push_exp(1, 0, d[4]);
    push_exp(1, 1, d[5]);
    arm(5, 1, 1'b0);
    send_beat(d[4], 1'b0);
    send_beat(d[5], 1'b1);
    end_directed("short", 2, 1, 0, d0 + 1);

    // tvalid pattern 1,0,0,1,... keeps addresses contiguous
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) push_exp(0, i, d[i + 2]);
    arm(4, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_beat(d[i + 2], i == 3);
      if (i != 3) idle(2);
    end
    end_directed("stalls", 4, 0, 0, d0 + 1);

    // beats in IDLE are refused; zero-length start is ignored
    tvalid = 1'b1;
    tdata  = d[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_tready", tready, 0);
      chk("idle_no_write", ram_we, 0);
    end
    tvalid = 1'b0;
    arm(0, 3, 1'b1);
    chk("len0_busy", busy, 0);
    idle(1);
    chk("len0_still_idle", tready, 0);

    // reset after 2 of 4 beats
    d0 = done_cnt;
    push_exp(5, 0, d[6]);
    push_exp(5, 1, d[7]);
    arm(4, 5, 1'b0);
    send_beat(d[6], 1'b0);
    send_beat(d[7], 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ram_we", ram_we, 0);
    chk("mid_rst_ram_din", ram_din, 0);
    chk("mid_rst_reg_adr", ram_reg_adr, 0);
    chk("mid_rst_mem_adr", ram_mem_adr, 0);
    chk("mid_rst_wl", words_loaded, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_tready", tready, 0);
      chk("post_rst_no_write", ram_we, 0);
    end
    tvalid = 1'b0;
    end_directed("mid_reset", 0, 0, 0, d0);
    sb_on = 1'b0;

    // randomised packets, stalls, stray starts and occasional resets
    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 4) == 0) arm(0, $urandom_range(0, NB - 1), 1'b1);
      arm($urandom_range(1, 6), $urandom_range(0, NB - 1), 1'($urandom_range(0, 1)));
      nb = $urandom_range(1, 20);
      for (int b = 0; b < nb; b++) begin
        stall = $urandom_range(0, 2);
        for (int s = 0; s < stall; s++) begin
          cfg_start    = ($urandom_range(0, 3) == 0);
          cfg_len      = AW'($urandom_range(0, 15));
          cfg_bank     = BW'($urandom_range(0, NB - 1));
          cfg_auto_inc = 1'($urandom_range(0, 1));
          tick();
          cfg_start = 1'b0;
        end
        if ($urandom_range(0, 60) == 0) begin
          rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
          break;
        end
        send_beat($urandom(), b == nb - 1);
      end
      idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_stream_loader.md
WEIGHT_STREAM_LOADER -- requirements
Module: weight_stream_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning stream and RAM data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning per-bank word-address width.
REQ-003 SHALL have parameter NUM_BANKS, default 8, meaning number of target RAM banks (power of two, >=2); BANK_W = clog2(NUM_BANKS).
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 s_axis_tdata  input  DATA_W  stream beat data.
REQ-007 s_axis_tvalid  input  1  beat valid.
REQ-008 s_axis_tlast  input  1  last beat of packet.
REQ-009 s_axis_tready  output  1  loader accepts beat.
REQ-010 cfg_start  input  1  single-cycle arm pulse.
REQ-011 cfg_len  input  ADDR_W  words per bank, sampled at cfg_start.
REQ-012 cfg_bank  input  BANK_W  first bank, sampled at cfg_start.
REQ-013 cfg_auto_inc  input  1  1 = spill into following banks, sampled at cfg_start.
REQ-014 ram_din  output  DATA_W  write data.
REQ-015 ram_reg_adr  output  ADDR_W  word address within bank.
REQ-016 ram_mem_adr  output  BANK_W  bank select.
REQ-017 ram_we  output  1  write strobe, one word per high cycle.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 done  output  1  single-cycle pulse at packet end.
REQ-020 err_short  output  1  sticky: tlast arrived before load complete.
REQ-021 err_over  output  1  sticky: beats arrived after load complete.
REQ-022 words_loaded  output  ADDR_W+BANK_W+1  words written since last cfg_start.

Function
REQ-023 States SHALL be IDLE, LOAD, DRAIN; beat accepted = tvalid & tready.
REQ-024 s_axis_tready SHALL be 0 in IDLE (backpressure until armed), 1 in LOAD and DRAIN.
REQ-025 IDLE: cfg_start with cfg_len!=0 SHALL latch len/bank/mode, clear err_short, err_over, words_loaded, address to 0, go LOAD next cycle; cfg_start with cfg_len==0 SHALL be ignored.
REQ-026 cfg_start outside IDLE SHALL be ignored.
REQ-027 LOAD: each accepted beat SHALL produce ram_we=1 exactly one cycle later with ram_din=beat data, ram_reg_adr/ram_mem_adr = current address/bank; all ram_* outputs registered.
REQ-028 After writing address len-1: if auto_inc=1 and bank<NUM_BANKS-1, bank SHALL increment, address SHALL return to 0, stay LOAD; else load complete.
REQ-029 Load complete on a beat with tlast=1 SHALL go IDLE and pulse done next cycle; with tlast=0 SHALL go DRAIN.
REQ-030 tlast accepted in LOAD before complete SHALL write that beat, set err_short, pulse done, go IDLE.
REQ-031 DRAIN: accepted beats SHALL NOT write RAM, SHALL set err_over; accepted tlast SHALL pulse done and go IDLE.
REQ-032 tvalid low in LOAD/DRAIN SHALL hold state and address (stall, no timeout).
REQ-033 Bank SHALL never wrap past NUM_BANKS-1; address arithmetic ADDR_W-bit, no wrap since compare at len-1.
REQ-034 words_loaded SHALL increment with each ram_we, saturating at all-ones.

Reset
REQ-035 RST_N low at a CLK edge SHALL force IDLE, tready=0, ram_we=0, ram_din=0, ram_reg_adr=0, ram_mem_adr=0, busy=0, done=0, err_short=0, err_over=0, words_loaded=0.
REQ-036 Reset mid-LOAD SHALL abort with no further writes; no done pulse.

Structure
REQ-037 State encoding and default parameter constants SHALL live in the shared params include/package.
REQ-038 Implementation SHALL be a single module with no sub-module; optional input skid register is internal.

Verification
REQ-039 cfg_len=4, bank=2, auto_inc=0; 4 beats D0..D3, tlast on D3 -> writes bank2 adr0..3, done once, no errors, words_loaded=4.
REQ-040 cfg_len=3, bank=6, auto_inc=1; 8 beats, tlast on 8th -> bank6 adr0..2, bank7 adr0..2, then DRAIN, err_over=1, done after beat 8, words_loaded=6.
REQ-041 cfg_len=5; tlast on beat 2 -> 2 writes, err_short=1, done, IDLE.
REQ-042 cfg_len=4; tvalid toggling 1,0,0,1,... -> writes contiguous addresses 0..3, no duplicate or skipped ram_we.
REQ-043 Beats presented in IDLE -> tready=0, no writes; cfg_start with cfg_len=0 -> stays IDLE.
REQ-044 RST_N low after 2 of 4 beats -> all outputs at reset values next cycle, no done, subsequent beats not accepted until new cfg_start.
